// File: rtl/texture_sampler_stream.sv
// Flow-controlled texel-quad sampler: per-axis wrap-mode address generation,
// fixed-delay memory capture and a credit-protected output skid FIFO.
module texture_sampler_stream #(
    parameter  int PIXEL_WIDTH   = 32,
    parameter  int MAX_SIZE_LOG2 = 8,
    parameter  int MEMORY_DELAY  = 1,
    parameter  int FIFO_DEPTH    = 8,
    localparam int ADDR_WIDTH    = 2 * MAX_SIZE_LOG2
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [3:0]             widthLog2,
    input  logic [3:0]             heightLog2,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [15:0]            s_texelS,
    input  logic [15:0]            s_texelT,
    input  logic [1:0]             s_modeS,
    input  logic [1:0]             s_modeT,
    output logic                   texelRead,
    output logic [ADDR_WIDTH-1:0]  texelAddr00,
    output logic [ADDR_WIDTH-1:0]  texelAddr01,
    output logic [ADDR_WIDTH-1:0]  texelAddr10,
    output logic [ADDR_WIDTH-1:0]  texelAddr11,
    input  logic [PIXEL_WIDTH-1:0] texelInput00,
    input  logic [PIXEL_WIDTH-1:0] texelInput01,
    input  logic [PIXEL_WIDTH-1:0] texelInput10,
    input  logic [PIXEL_WIDTH-1:0] texelInput11,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIXEL_WIDTH-1:0] m_texel00,
    output logic [PIXEL_WIDTH-1:0] m_texel01,
    output logic [PIXEL_WIDTH-1:0] m_texel10,
    output logic [PIXEL_WIDTH-1:0] m_texel11,
    output logic [15:0]            m_subCoordS,
    output logic [15:0]            m_subCoordT
);
    localparam int IW = MAX_SIZE_LOG2;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (MEMORY_DELAY < 1 || FIFO_DEPTH < MEMORY_DELAY + 3) begin : g_param_check
        $error("texture_sampler_stream: need MEMORY_DELAY>=1 and FIFO_DEPTH>=MEMORY_DELAY+3");
    end

    typedef struct packed {
        logic [IW-1:0] i0;
        logic [IW-1:0] i1;
        logic [15:0]   frac;
    } axis_t;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] t00, t01, t10, t11;
        logic [15:0]            subS, subT;
    } entry_t;

    function automatic axis_t map_axis(input logic [15:0] c, input logic [1:0] mode,
                                       input logic [3:0] lg);
        axis_t         r;
        logic [14:0]   f;
        logic [IW-1:0] mx;
        f      = (mode == 2'd2 && c[15]) ? ~c[14:0] : c[14:0];
        mx     = IW'((32'd1 << lg) - 32'd1);
        r.i0   = IW'(f >> (4'd15 - lg));
        r.frac = (lg == 4'd0) ? 16'd0 : ({f, 1'b0} << lg);
        // Top edge: repeat (and the reserved mode 3) wraps to 0, clamp/mirror stick at the edge.
        if (r.i0 == mx) r.i1 = (mode == 2'd1 || mode == 2'd2) ? mx : '0;
        else            r.i1 = r.i0 + IW'(1);
        if (mode == 2'd1 && c[15]) begin
            r.i0   = mx;
            r.i1   = mx;
            r.frac = '0;
        end
        return r;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [IW-1:0] t, input logic [IW-1:0] s,
                                                      input logic [3:0] wl);
        return (ADDR_WIDTH'(t) << wl) | ADDR_WIDTH'(s);
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    axis_t sa, ta;
    logic  accept, push, pop;

    assign sa     = map_axis(s_texelS, s_modeS, widthLog2);
    assign ta     = map_axis(s_texelT, s_modeT, heightLog2);
    assign accept = s_valid && s_ready;
    assign pop    = m_valid && m_ready;

    // vld_pipe_q[0] is the memory strobe; bit MEMORY_DELAY marks the cycle its data is on texelInput*.
    logic [MEMORY_DELAY:0]       vld_pipe_q;
    logic [MEMORY_DELAY:0][31:0] frac_pipe_q;
    logic [ADDR_WIDTH-1:0]       addr00_q, addr01_q, addr10_q, addr11_q;

    assign texelRead   = vld_pipe_q[0];
    assign push        = vld_pipe_q[MEMORY_DELAY];
    assign texelAddr00 = addr00_q;
    assign texelAddr01 = addr01_q;
    assign texelAddr10 = addr10_q;
    assign texelAddr11 = addr11_q;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe_q  <= '0;
            frac_pipe_q <= '0;
            addr00_q    <= '0;
            addr01_q    <= '0;
            addr10_q    <= '0;
            addr11_q    <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[MEMORY_DELAY-1:0], accept};
            frac_pipe_q <= {frac_pipe_q[MEMORY_DELAY-1:0], {sa.frac, ta.frac}};
            if (accept) begin
                addr00_q <= mk_addr(ta.i0, sa.i0, widthLog2);
                addr01_q <= mk_addr(ta.i0, sa.i1, widthLog2);
                addr10_q <= mk_addr(ta.i1, sa.i0, widthLog2);
                addr11_q <= mk_addr(ta.i1, sa.i1, widthLog2);
            end
        end
    end

    // Credit: every accepted request already owns a FIFO slot, so the memory path never stalls.
    logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;

    assign s_ready = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
    assign m_valid = (count_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !push)      inflight_d = inflight_q + CW'(1);
        else if (!accept && push) inflight_d = inflight_q - CW'(1);
        count_d = count_q;
        if (push && !pop)         count_d = count_q + CW'(1);
        else if (!push && pop)    count_d = count_q - CW'(1);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= nxt(wr_ptr_q);
            if (pop)  rd_ptr_q <= nxt(rd_ptr_q);
        end
    end

    entry_t mem_q [FIFO_DEPTH];
    entry_t head;

    always_ff @(posedge aclk) begin
        if (push)
            mem_q[wr_ptr_q] <= {texelInput00, texelInput01, texelInput10, texelInput11,
                                frac_pipe_q[MEMORY_DELAY]};
    end

    // Payload is forced to zero while empty so stale storage never shows on the outputs.
    assign head        = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_texel00   = head.t00;
    assign m_texel01   = head.t01;
    assign m_texel10   = head.t10;
    assign m_texel11   = head.t11;
    assign m_subCoordS = head.subS;
    assign m_subCoordT = head.subT;

endmodule
